// File: rtl/sdu_pkg.sv
// rtl/sdu_pkg.sv - shared states and ASCII constants for the serial debug unit
// SDU_HEX_CRLF_EN selects the CR LF line terminator; a single space is used otherwise.
package sdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_SEP   = 2'd2
  } sdu_state_e;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;

`ifdef SDU_HEX_CRLF_EN
  localparam int NSEP = 2;
`else
  localparam int NSEP = 1;
`endif

endpackage

// File: rtl/sdu_nib2asc.sv
// rtl/sdu_nib2asc.sv - combinational nibble to uppercase ASCII hex digit
module sdu_nib2asc
  import sdu_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  always_comb begin
    if (nib_i < 4'd10) asc_o = ASC_0 + {4'b0000, nib_i};
    else               asc_o = ASC_A + {4'b0000, nib_i - 4'd10};
  end

endmodule

// File: rtl/sdu_hex_tx_fmt.sv
// rtl/sdu_hex_tx_fmt.sv - prints latched debug words as uppercase hex text to the UART transmitter
// SDU_HEX_CRLF_EN: terminate each word with CR LF instead of a single space.
module sdu_hex_tx_fmt
  import sdu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] word,
  input  logic          vld_in,
  output logic          rdy_in,
  output logic [7:0]    d_tx,
  output logic          vld_tx,
  input  logic          rdy_tx,
  output logic          busy
);

  localparam int NDIG = DW / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  sdu_state_e    state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dig_asc;
  logic [7:0]    sep_byte;
  logic          accept;
  logic          xfer;

`ifdef SDU_HEX_CRLF_EN
  logic sep_q, sep_d;
  assign sep_byte = sep_q ? ASC_LF : ASC_CR;
`else
  assign sep_byte = ASC_SP;
`endif

  sdu_nib2asc u_nib2asc (
    .nib_i (shreg_q[DW-1 -: 4]),
    .asc_o (dig_asc)
  );

  assign accept = vld_in && rdy_in;
  assign xfer   = vld_tx && rdy_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SDU_HEX_CRLF_EN
      sep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SDU_HEX_CRLF_EN
      sep_q   <= sep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SDU_HEX_CRLF_EN
    sep_d   = sep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = word;
          cnt_d   = '0;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          shreg_d = shreg_q << 4;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_DIG) state_d = ST_SEP;
        end
      end
      ST_SEP: begin
`ifdef SDU_HEX_CRLF_EN
        // sep_q selects CR then LF; it is cleared on leaving so the next word starts at CR
        if (xfer) begin
          sep_d = ~sep_q;
          if (sep_q) state_d = ST_IDLE;
        end
`else
        if (xfer) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only, so rdy_tx/vld_in never reach them combinationally.
  always_comb begin
    rdy_in = 1'b0;
    vld_tx = 1'b0;
    busy   = 1'b0;
    d_tx   = 8'h00;
    case (state_q)
      ST_IDLE:  rdy_in = 1'b1;
      ST_DIGIT: begin
        vld_tx = 1'b1;
        busy   = 1'b1;
        d_tx   = dig_asc;
      end
      ST_SEP: begin
        vld_tx = 1'b1;
        busy   = 1'b1;
        d_tx   = sep_byte;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdu_hex_tx_fmt.sv
// tb/tb_sdu_hex_tx_fmt.sv - directed self-checking bench for sdu_hex_tx_fmt
// Honours SDU_HEX_CRLF_EN for the expected terminator bytes.
module tb_sdu_hex_tx_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic        vld_in;
  logic        rdy_in;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic        busy;

  logic [15:0] word16;
  logic        vld16;
  logic        rdy_in16;
  logic [7:0]  d_tx16;
  logic        vld_tx16;
  logic        rdy_tx16;
  logic        busy16;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sdu_hex_tx_fmt #(.DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .word   (word),
    .vld_in (vld_in),
    .rdy_in (rdy_in),
    .d_tx   (d_tx),
    .vld_tx (vld_tx),
    .rdy_tx (rdy_tx),
    .busy   (busy)
  );

  sdu_hex_tx_fmt #(.DW(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .word   (word16),
    .vld_in (vld16),
    .rdy_in (rdy_in16),
    .d_tx   (d_tx16),
    .vld_tx (vld_tx16),
    .rdy_tx (rdy_tx16),
    .busy   (busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic add_term();
`ifdef SDU_HEX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic build_exp(input logic [31:0] w, input int ndig);
    logic [3:0] nib;
    exp_q.delete();
    for (int i = 0; i < ndig; i++) begin
      nib = 4'((w >> (4 * (ndig - 1 - i))) & 32'hF);
      if (nib < 4'd10) exp_q.push_back(8'h30 + {4'h0, nib});
      else             exp_q.push_back(8'h37 + {4'h0, nib});
    end
    add_term();
  endtask

  task automatic accept(input logic [31:0] w);
    chk("rdy_in_before_accept", rdy_in, 1);
    vld_in = 1'b1;
    word   = w;
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    word   = '0;
  endtask

  task automatic run_bytes(input int nlim, input int stall_at, input int stall_n);
    for (int i = 0; i < nlim; i++) begin
      chk($sformatf("vld_tx[%0d]", i), vld_tx, 1);
      chk($sformatf("d_tx[%0d]", i), d_tx, exp_q[i]);
      chk($sformatf("busy[%0d]", i), busy, 1);
      chk($sformatf("rdy_in_busy[%0d]", i), rdy_in, 0);
      if (i == stall_at) begin
        rdy_tx = 1'b0;
        repeat (stall_n) begin
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("hold_d_tx[%0d]", i), d_tx, exp_q[i]);
          chk($sformatf("hold_vld_tx[%0d]", i), vld_tx, 1);
        end
        rdy_tx = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (nlim == exp_q.size()) begin
      chk("idle_rdy_in", rdy_in, 1);
      chk("idle_vld_tx", vld_tx, 0);
      chk("idle_busy", busy, 0);
      chk("idle_d_tx", d_tx, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; word = '0; vld_in = 1'b0; rdy_tx = 1'b1;
    word16 = '0; vld16 = 1'b0; rdy_tx16 = 1'b1;
    @(negedge clk);
    chk("rst_rdy_in", rdy_in, 1);
    chk("rst_vld_tx", vld_tx, 0);
    chk("rst_d_tx", d_tx, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1234ABCD with hand-written digits, no stall
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    add_term();
    accept(32'h1234ABCD);
    run_bytes(exp_q.size(), -1, 0);

    // same word, third byte stalled for five cycles
    accept(32'h1234ABCD);
    run_bytes(exp_q.size(), 2, 5);

    // FFFFFFFF offered throughout an active 00000000 word
    build_exp(32'h00000000, 8);
    accept(32'h00000000);
    vld_in = 1'b1;
    word   = 32'hFFFFFFFF;
    run_bytes(exp_q.size(), -1, 0);
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    word   = '0;
    build_exp(32'hFFFFFFFF, 8);
    chk("ffff_first", d_tx, 8'h46);
    run_bytes(exp_q.size(), -1, 0);

    // asynchronous reset after the fourth digit of DEADBEEF
    build_exp(32'hDEADBEEF, 8);
    accept(32'hDEADBEEF);
    run_bytes(4, -1, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld_tx", vld_tx, 0);
    chk("mid_rst_d_tx", d_tx, 0);
    chk("mid_rst_rdy_in", rdy_in, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_vld_tx", vld_tx, 0);
    build_exp(32'h00000001, 8);
    accept(32'h00000001);
    run_bytes(exp_q.size(), -1, 0);

    // letter digit in the last position
    build_exp(32'h0000000A, 8);
    accept(32'h0000000A);
    run_bytes(exp_q.size(), -1, 0);

    // 16-bit instance: BEEF
    exp_q = '{8'h42, 8'h45, 8'h45, 8'h46};
    add_term();
    chk("dw16_rdy_in", rdy_in16, 1);
    vld16  = 1'b1;
    word16 = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    vld16 = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("dw16_vld_tx[%0d]", i), vld_tx16, 1);
      chk($sformatf("dw16_d_tx[%0d]", i), d_tx16, exp_q[i]);
      @(posedge clk);
      @(negedge clk);
    end
    chk("dw16_idle_rdy_in", rdy_in16, 1);
    chk("dw16_idle_vld_tx", vld_tx16, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
